// File: rtl/score_pulse_gen_if.sv
// Handshake bundle between the scoring logic and the pulse generator:
// scoring events in, display pulse train and status out.
interface score_pulse_gen_if;
  logic       score_valid;
  logic [3:0] get_score;
  logic       game_end;
  logic       score_signal;
  logic [7:0] pending;
  logic       busy;
  logic       overflow;

  modport master (
    output score_valid, get_score, game_end,
    input  score_signal, pending, busy, overflow
  );

  modport slave (
    input  score_valid, get_score, game_end,
    output score_signal, pending, busy, overflow
  );
endinterface

// File: rtl/score_pulse_gen.sv
// Turns multi-point scoring events into a train of one-point pulses for a
// downstream display counter; points queue up in a saturating pending count.
module score_pulse_gen #(
  parameter int PULSE_HIGH = 2,
  parameter int PULSE_LOW  = 2
) (
  input  logic              sclk,
  input  logic              rst,
  score_pulse_gen_if.slave  bus
);

  localparam logic [3:0] HIGH_LAST = 4'(PULSE_HIGH - 1);
  localparam logic [3:0] LOW_LAST  = 4'(PULSE_LOW - 1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t     state;
  logic [3:0] phase;
  logic [7:0] pending;
  logic       pulse;
  logic       ovf;

  logic       accept;
  logic [3:0] pts;
  logic       dec;
  logic [9:0] sum;

  function automatic logic [7:0] sat_u8(input logic [9:0] x);
    return (x > 10'd255) ? 8'hFF : x[7:0];
  endfunction

  assign accept = bus.score_valid && !bus.game_end && (bus.get_score != 4'd0);
  assign pts    = accept ? bus.get_score : 4'd0;

  // A point is consumed on exactly the edges that start a new high phase.
  assign dec = (pending != 8'd0) &&
               ((state == IDLE) || (state == LOW && phase == LOW_LAST));

  assign sum = {2'b00, pending} + {6'd0, pts} - {9'd0, dec};

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      phase   <= 4'd0;
      pending <= 8'd0;
      pulse   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      pending <= sat_u8(sum);
      if (sum > 10'd255) ovf <= 1'b1;

      case (state)
        IDLE: begin
          phase <= 4'd0;
          if (dec) begin
            state <= HIGH;
            pulse <= 1'b1;
          end
        end
        HIGH: begin
          if (phase == HIGH_LAST) begin
            state <= LOW;
            phase <= 4'd0;
            pulse <= 1'b0;
          end else begin
            phase <= phase + 4'd1;
          end
        end
        LOW: begin
          if (phase == LOW_LAST) begin
            phase <= 4'd0;
            if (dec) begin
              state <= HIGH;
              pulse <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else begin
            phase <= phase + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          phase <= 4'd0;
          pulse <= 1'b0;
        end
      endcase
    end
  end

  assign bus.score_signal = pulse;
  assign bus.pending      = pending;
  assign bus.overflow     = ovf;
  assign bus.busy         = (pending != 8'd0) || (state != IDLE);

endmodule

// File: tb/tb_score_pulse_gen.sv
// Directed bench for score_pulse_gen: expected pulse counts and rise times
// are queued at stimulus time and checked against the observed pulse train.
module tb_score_pulse_gen;

  localparam int PH = 2;
  localparam int PL = 2;

  logic sclk = 1'b0;
  logic rst  = 1'b1;
  int   cyc  = 0;

  score_pulse_gen_if bus ();

  score_pulse_gen #(.PULSE_HIGH(PH), .PULSE_LOW(PL)) dut (
    .sclk (sclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 sclk = ~sclk;
  always @(posedge sclk) cyc <= cyc + 1;

  // Pulse-train monitor, sampling on the falling edge.
  int rise_cyc [1024];
  int high_len [1024];
  int rise_cnt = 0;
  int fall_cnt = 0;
  int hcnt = 0;
  int skip_viol = 0;
  int prev_pend = 0;
  logic prev_sig = 1'b0;
  logic have_prev = 1'b0;
  logic armed = 1'b0;

  always @(negedge sclk) begin
    if (rst) begin
      prev_sig  <= 1'b0;
      hcnt      <= 0;
      have_prev <= 1'b0;
      armed     <= 1'b0;
    end else begin
      prev_sig <= bus.score_signal;
      if (bus.score_signal && !prev_sig) begin
        rise_cyc[rise_cnt] <= cyc;
        rise_cnt <= rise_cnt + 1;
      end
      if (bus.score_signal) hcnt <= hcnt + 1;
      else if (prev_sig) begin
        high_len[fall_cnt] <= hcnt;
        fall_cnt <= fall_cnt + 1;
        hcnt <= 0;
      end
      if (have_prev && !armed &&
          !(prev_pend == int'(bus.pending) || prev_pend == int'(bus.pending) + 1))
        skip_viol <= skip_viol + 1;
      prev_pend <= int'(bus.pending);
      have_prev <= 1'b1;
      armed <= bus.score_valid && !bus.game_end && (bus.get_score != 4'd0);
    end
  end

  int checks = 0;
  int passes = 0;
  int exp_tot_q [$];
  int exp_rise_q [$];

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic accept_pts(input int p);
    bus.score_valid = 1'b1;
    bus.get_score   = 4'(p);
    tick();
    bus.score_valid = 1'b0;
    bus.get_score   = 4'd0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n = 0;
    while (bus.busy && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_busy_timeout"}, int'(bus.busy), 0);
  endtask

  task automatic check_drain(input string tag, input int rbase, input int fbase,
                             input int sbase);
    int exp;
    wait_idle(tag, 3000);
    tick();
    exp = exp_tot_q.pop_front();
    chk({tag, "_rises"}, rise_cnt - rbase, exp);
    chk({tag, "_falls"}, fall_cnt - fbase, exp);
    for (int k = 0; k < fall_cnt - fbase; k++)
      chk({tag, "_high_len"}, high_len[fbase + k], PH);
    for (int k = 1; k < rise_cnt - rbase; k++)
      chk({tag, "_period"}, rise_cyc[rbase + k] - rise_cyc[rbase + k - 1], PH + PL);
    chk({tag, "_pend_skip"}, skip_viol - sbase, 0);
    chk({tag, "_pending0"}, int'(bus.pending), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, rb, fb, sb;
    bus.score_valid = 1'b0;
    bus.get_score   = 4'd0;
    bus.game_end    = 1'b0;

    // Reset values without any clock edge.
    #2;
    chk("rst_sig",  int'(bus.score_signal), 0);
    chk("rst_pend", int'(bus.pending), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_ovf",  int'(bus.overflow), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_sig", int'(bus.score_signal), 0);

    // Single event of 3 points.
    rb = rise_cnt; fb = fall_cnt; sb = skip_viol;
    accept_pts(3);
    e = cyc;
    exp_tot_q.push_back(3);
    exp_rise_q.push_back(e + 1);
    exp_rise_q.push_back(e + 5);
    exp_rise_q.push_back(e + 9);
    chk("s3_pend_E", int'(bus.pending), 3);
    chk("s3_sig_E",  int'(bus.score_signal), 0);
    chk("s3_busy_E", int'(bus.busy), 1);
    tick();
    chk("s3_sig_E1",  int'(bus.score_signal), 1);
    chk("s3_pend_E1", int'(bus.pending), 2);
    while (cyc < e + 12) tick();
    chk("s3_busy_E12", int'(bus.busy), 1);
    tick();
    chk("s3_busy_E13", int'(bus.busy), 0);
    for (int k = 0; k < 3; k++)
      chk("s3_rise_time", rise_cyc[rb + k], exp_rise_q.pop_front());
    check_drain("s3", rb, fb, sb);

    // Overlapping events: 5, then 4 while the second pulse is high.
    rb = rise_cnt; fb = fall_cnt; sb = skip_viol;
    accept_pts(5);
    e = cyc;
    exp_tot_q.push_back(9);
    while (cyc < e + 5) tick();
    chk("ov_sig_2nd", int'(bus.score_signal), 1);
    accept_pts(4);
    chk("ov_pend_after", int'(bus.pending), 7);
    check_drain("ov", rb, fb, sb);

    // Saturation: 18 back-to-back 15-point events.
    rb = rise_cnt; fb = fall_cnt; sb = skip_viol;
    exp_tot_q.push_back(260);
    bus.score_valid = 1'b1;
    bus.get_score   = 4'd15;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (i == 16) begin
        chk("sat_pend_251", int'(bus.pending), 251);
        chk("sat_ovf_0",    int'(bus.overflow), 0);
      end
    end
    bus.score_valid = 1'b0;
    bus.get_score   = 4'd0;
    chk("sat_pend_255", int'(bus.pending), 255);
    chk("sat_ovf_1",    int'(bus.overflow), 1);
    chk("sat_rises_so_far", rise_cnt - rb, 4);
    check_drain("sat", rb, fb, sb);
    chk("sat_ovf_sticky", int'(bus.overflow), 1);

    // game_end blocks strobes but pending points still drain.
    rb = rise_cnt; fb = fall_cnt; sb = skip_viol;
    accept_pts(4);
    exp_tot_q.push_back(4);
    bus.game_end = 1'b1;
    chk("ge_pend_E", int'(bus.pending), 4);
    accept_pts(7);
    chk("ge_pend_E1", int'(bus.pending), 3);
    tick();
    accept_pts(7);
    chk("ge_pend_E3", int'(bus.pending), 3);
    check_drain("ge", rb, fb, sb);
    bus.game_end = 1'b0;

    // Reset mid-pulse with 6 points still pending.
    accept_pts(7);
    tick();
    chk("rp_sig_high", int'(bus.score_signal), 1);
    chk("rp_pend_6",   int'(bus.pending), 6);
    #2 rst = 1'b1;
    #1;
    chk("rp_sig",  int'(bus.score_signal), 0);
    chk("rp_pend", int'(bus.pending), 0);
    chk("rp_busy", int'(bus.busy), 0);
    chk("rp_ovf",  int'(bus.overflow), 0);
    tick();
    tick();
    rst = 1'b0;
    rb = rise_cnt;
    repeat (10) tick();
    chk("rp_no_rise", rise_cnt - rb, 0);
    chk("rp_busy_after", int'(bus.busy), 0);
    rb = rise_cnt; fb = fall_cnt; sb = skip_viol;
    accept_pts(1);
    e = cyc;
    exp_tot_q.push_back(1);
    tick();
    chk("rp_new_rise", int'(bus.score_signal), 1);
    check_drain("rp", rb, fb, sb);
    chk("rp_new_rise_time", rise_cyc[rb], e + 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/score_pulse_gen.md
SCORE_PULSE_GEN -- requirements
Module: score_pulse_gen

Interface
REQ-001 SHALL have parameter PULSE_HIGH, default 2, sclk cycles score_signal is held high per pulse (legal range 1-15).
REQ-002 SHALL have parameter PULSE_LOW, default 2, sclk cycles score_signal is held low between pulses (legal range 1-15).
REQ-003 SHALL have port sclk  input  1  clock; all state is updated on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port score_valid  input  1  one-cycle strobe marking a scoring event.
REQ-006 SHALL have port get_score  input  4  points awarded by the event (0-15), sampled when score_valid=1.
REQ-007 SHALL have port game_end  input  1  level; when high, no new points are accepted.
REQ-008 SHALL have port score_signal  output  1  registered pulse train; each rising edge is exactly one point for the display counter.
REQ-009 SHALL have port pending  output  8  points accepted but not yet emitted.
REQ-010 SHALL have port busy  output  1  high while pending!=0 or the FSM is not in IDLE.
REQ-011 SHALL have port overflow  output  1  sticky flag; set when points are lost to saturation.

Function
REQ-012 SHALL accept an event at an edge where score_valid=1, game_end=0 and get_score!=0; get_score=0 SHALL be a no-op.
REQ-013 SHALL update pending each edge as pending + accepted_points - dec, where dec=1 on an edge that enters HIGH, computed 9+ bits wide and saturated at 255.
REQ-014 SHALL set overflow when the unsaturated result exceeds 255; it SHALL stay set until rst.
REQ-015 SHALL implement FSM states IDLE, HIGH and LOW, with a 4-bit phase counter.
REQ-016 IDLE -> HIGH SHALL occur at the first edge where pending!=0; that same edge sets score_signal=1 and applies dec=1.
REQ-017 HIGH SHALL last exactly PULSE_HIGH cycles, then go to LOW with score_signal=0.
REQ-018 LOW SHALL last exactly PULSE_LOW cycles, then go to HIGH (dec=1) if pending!=0, else to IDLE.
REQ-019 Latency: with pending=0 in IDLE, an accept at edge E SHALL make score_signal rise at edge E+1.
REQ-020 Pulse period SHALL be PULSE_HIGH+PULSE_LOW cycles while draining; no runt or merged pulses.
REQ-021 An accept concurrent with a dec SHALL lose neither (net change = points-1).
REQ-022 game_end SHALL block new accepts only; already-pending points SHALL still drain completely, and an in-progress pulse SHALL complete.
REQ-023 score_signal SHALL be driven directly from a flop (glitch-free, usable as a clock edge downstream).
REQ-024 busy SHALL fall at the edge that returns the FSM to IDLE with pending=0.
REQ-025 Total score_signal rising edges SHALL equal the sum of accepted points, minus points lost to saturation.

Reset
REQ-026 On rst=1, asynchronously: state=IDLE, phase counter=0, score_signal=0, pending=0, busy=0, overflow=0.
REQ-027 Reset asserted mid-pulse SHALL drop score_signal to 0 immediately and discard all pending points.
REQ-028 After rst deasserts, the first edge SHALL behave as IDLE with pending=0.

Verification
REQ-029 Reset: assert rst at arbitrary time -> score_signal=0, pending=0, busy=0, overflow=0 without a clock edge.
REQ-030 Single event get_score=3 at edge E -> 3 pulses, rises at E+1, E+5, E+9, each 2 cycles high; busy=0 from edge E+13.
REQ-031 Overlap: get_score=5, then get_score=4 during the 2nd pulse -> exactly 9 pulses, no gaps beyond PULSE_LOW, pending never skips a value.
REQ-032 Saturation: preload pending to 250 with no drain edge, then get_score=15 -> pending=255, overflow=1; exactly 255 further pulses.
REQ-033 game_end=1 with pending=4 and score_valid pulses (get_score=7) -> strobes ignored, exactly 4 pulses emitted, then busy=0.
REQ-034 rst during HIGH phase with pending=6 -> score_signal=0 at once; after release, no pulses until a new accept.
